// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters kclk, deserializes 11-bit frames into scan codes.
// Define PS2_RX_PARITY_CHECK_EN to drop odd-parity failures; otherwise the parity bit is ignored.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic          kclk_s1_q, kclk_s_q, kdata_s1_q, kdata_s_q;
  logic          kclk_f_q, kclk_f_d, kclk_dly_q;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic          fall, timeout, parity_ok;

  // kclk_f only follows kclk_s after FILTER_LEN consecutive differing samples
  always_comb begin
    kclk_f_d  = kclk_f_q;
    flt_cnt_d = '0;
    if (kclk_s_q != kclk_f_q) begin
      if (flt_cnt_q == FLT_MAX) kclk_f_d = ~kclk_f_q;
      else                      flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall      = kclk_dly_q & ~kclk_f_q;
  assign timeout   = (state_q != IDLE) && (to_cnt_q == TO_MAX) && !fall;
  assign parity_ok = ^{shreg_q, par_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      kclk_s1_q  <= 1'b1;
      kclk_s_q   <= 1'b1;
      kdata_s1_q <= 1'b1;
      kdata_s_q  <= 1'b1;
      kclk_f_q   <= 1'b1;
      kclk_dly_q <= 1'b1;
      flt_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      keycode_q  <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kclk_s1_q  <= kclk_i;
      kclk_s_q   <= kclk_s1_q;
      kdata_s1_q <= kdata_i;
      kdata_s_q  <= kdata_s1_q;
      kclk_f_q   <= kclk_f_d;
      kclk_dly_q <= kclk_f_q;
      flt_cnt_q  <= flt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      keycode_q  <= keycode_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE:    if (!kdata_s_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    keycode_d = keycode_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = timeout;
    to_cnt_d  = (fall || state_q == IDLE) ? '0 : to_cnt_q + 1'b1;
    if (fall) begin
      case (state_q)
        IDLE: bit_cnt_d = '0;
        DATA: begin
          shreg_d   = {kdata_s_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: par_d = kdata_s_q;
        STOP: begin
          if (!kdata_s_q)               ferr_d = 1'b1;
          else if (PAR_EN && !parity_ok) perr_d = 1'b1;
          else begin
            valid_d   = 1'b1;
            keycode_d = shreg_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign keycode_o       = keycode_q;
  assign keycode_valid_o = valid_q;
  assign parity_err_o    = perr_q;
  assign frame_err_o     = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good/bad-parity/bad-stop frames, glitch rejection, timeout, mid-frame reset.
module tb_ps2_rx;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic       clk_i = 1'b0, rst_ni = 1'b0, kclk_i = 1'b1, kdata_i = 1'b1;
  logic [7:0] keycode_o;
  logic       keycode_valid_o, parity_err_o, frame_err_o;

  int tests = 0, fails = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
  int v0, p0, f0, lat;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .kclk_i(kclk_i), .kdata_i(kdata_i),
    .keycode_o(keycode_o), .keycode_valid_o(keycode_valid_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    n_valid += int'(keycode_valid_o);
    n_perr  += int'(parity_err_o);
    n_ferr  += int'(frame_err_o);
    if (int'(keycode_valid_o) + int'(parity_err_o) + int'(frame_err_o) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
  endtask

  // lat = posedges from the kclk_i fall to the first status pulse (0 if none)
  task automatic send_bit(input logic b, output int l);
    l = 0;
    @(negedge clk_i); kdata_i = b;
    repeat (HALF) @(negedge clk_i);
    kclk_i = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      @(posedge clk_i); #1;
      if (l == 0 && (keycode_valid_o | parity_err_o | frame_err_o)) l = i + 1;
    end
    @(negedge clk_i); kclk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int l);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], l);
    repeat (100) @(negedge clk_i);
  endtask

  initial begin
    repeat (5) @(posedge clk_i);
    #1;
    check("rst_keycode", 32'(keycode_o), 32'h00);
    check("rst_valid", 32'(keycode_valid_o), 0);
    check("rst_perr", 32'(parity_err_o), 0);
    check("rst_ferr", 32'(frame_err_o), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);

    snap(); send_frame(8'h1C, 1'b0, 1'b1, lat);
    check("good_1c_latency", 32'(lat), 32'(FL + 3));
    check("good_1c_valid", 32'(n_valid - v0), 1);
    check("good_1c_perr", 32'(n_perr - p0), 0);
    check("good_1c_ferr", 32'(n_ferr - f0), 0);
    check("good_1c_code", 32'(keycode_o), 32'h1C);

    snap(); send_frame(8'h29, 1'b0, 1'b0, lat);
    check("stop0_ferr", 32'(n_ferr - f0), 1);
    check("stop0_valid", 32'(n_valid - v0), 0);
    check("stop0_code", 32'(keycode_o), 32'h1C);

    snap(); send_frame(8'h29, 1'b0, 1'b1, lat);
    check("good_29_valid", 32'(n_valid - v0), 1);
    check("good_29_code", 32'(keycode_o), 32'h29);

    snap(); send_frame(8'h1C, 1'b1, 1'b1, lat);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("badpar_perr", 32'(n_perr - p0), 1);
    check("badpar_valid", 32'(n_valid - v0), 0);
    check("badpar_code", 32'(keycode_o), 32'h29);
`else
    check("badpar_perr", 32'(n_perr - p0), 0);
    check("badpar_valid", 32'(n_valid - v0), 1);
    check("badpar_code", 32'(keycode_o), 32'h1C);
`endif

    // kclk low for FL-1 cycles with data low must not start a frame
    snap();
    @(negedge clk_i); kdata_i = 1'b0; kclk_i = 1'b0;
    repeat (FL - 1) @(negedge clk_i);
    kclk_i = 1'b1;
    repeat (50) @(negedge clk_i);
    kdata_i = 1'b1;
    repeat (50) @(negedge clk_i);
    check("glitch_pulses", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 0);
    snap(); send_frame(8'hF0, 1'b1, 1'b1, lat);
    check("after_glitch_valid", 32'(n_valid - v0), 1);
    check("after_glitch_code", 32'(keycode_o), 32'hF0);

    // start + 3 data bits, then kclk held high
    snap();
    send_bit(1'b0, lat); send_bit(1'b0, lat); send_bit(1'b1, lat); send_bit(1'b0, lat);
    repeat (1500) @(negedge clk_i);
    check("timeout_early", 32'(n_ferr - f0), 0);
    repeat (1100) @(negedge clk_i);
    check("timeout_ferr", 32'(n_ferr - f0), 1);
    check("timeout_valid", 32'(n_valid - v0), 0);
    snap(); send_frame(8'h5A, 1'b1, 1'b1, lat);
    check("after_to_valid", 32'(n_valid - v0), 1);
    check("after_to_code", 32'(keycode_o), 32'h5A);

    // 0x1C start + bits 0..3, reset, then bits 4..7, parity 0, stop 1
    snap();
    send_bit(1'b0, lat); send_bit(1'b0, lat); send_bit(1'b0, lat);
    send_bit(1'b1, lat); send_bit(1'b1, lat);
    @(negedge clk_i); rst_ni = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    #1;
    check("midrst_code", 32'(keycode_o), 32'h00);
    check("midrst_flags", 32'({keycode_valid_o, parity_err_o, frame_err_o}), 0);
    check("midrst_pulses", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 0);
    send_bit(1'b1, lat); send_bit(1'b0, lat); send_bit(1'b0, lat);
    send_bit(1'b0, lat); send_bit(1'b0, lat); send_bit(1'b1, lat);
    // bit4 (1) is ignored in IDLE, bit5 (0) looks like a start, the rest leave
    // a 4-bit partial frame that then times out
    repeat (2600) @(negedge clk_i);
    check("resume_valid", 32'(n_valid - v0), 0);
    check("resume_ferr", 32'(n_ferr - f0), 1);
    check("resume_code", 32'(keycode_o), 32'h00);
    snap(); send_frame(8'h5A, 1'b1, 1'b1, lat);
    check("fresh_5a_valid", 32'(n_valid - v0), 1);
    check("fresh_5a_code", 32'(keycode_o), 32'h5A);

    check("pulse_exclusive", 32'(n_multi), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
